// File: rtl/hazard_unit_mdu.sv
// Pipeline hazard controller: operand forwarding, load-use stall, redirect flush,
// multi-cycle MDU hold in Execute and a saturating stall-cycle counter.
module hazard_unit_mdu #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic [1:0]        PCSrcE,
  input  logic              MduStartE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MduDoneE,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int unsigned CW       = $clog2(MDU_LAT + 1);
  localparam bit          MULTI    = (MDU_LAT > 1);
  localparam logic [CW-1:0] CNT_IDLE = CW'(0);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] SC_MAX = {CNT_W{1'b1}};

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic             lu, redirect, mdu_hold, stall_f_int;

  // MDU occupancy counter: IDLE (0) loads, BUSY (>1) counts down, LAST (1) releases
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == CNT_IDLE) begin
      if (MduStartE && MULTI) cnt_d = CNT_LOAD;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_IDLE;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= CNT_IDLE;
      sc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sc_q  <= sc_d;
    end
  end

  assign lu          = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign redirect    = (PCSrcE != 2'b00);
  assign mdu_hold    = MduStartE && MULTI && (cnt_q != CNT_LAST);
  assign stall_f_int = mdu_hold || lu;

  always_comb begin
    sc_d = sc_q;
    if (stall_f_int && (sc_q != SC_MAX)) sc_d = sc_q + CNT_W'(1);
  end

  // Combinational controls, all forced low while reset is asserted
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    MduDoneE  = 1'b0;
    if (rst) begin
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
      MduDoneE = MduStartE && ((cnt_q == CNT_LAST) || !MULTI);
      // A held MDU op defers load-use: D/E keep their contents until release
      if (mdu_hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else begin
        StallF = lu;
        StallD = lu;
        FlushE = lu || redirect;
        FlushD = redirect;
      end
    end
  end

  assign StallCount = sc_q;

endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Directed bench for hazard_unit_mdu: default instance (MDU_LAT=4, CNT_W=16) and a
// single-cycle-MDU instance with a 2-bit stall counter sharing the same inputs.
module tb_hazard_unit_mdu;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MduStartE;
  logic [1:0] ResultSrcE, PCSrcE;

  logic        sf_a, sd_a, se_a, fd_a, fe_a, fm_a, dn_a;
  logic [1:0]  fa_a, fb_a;
  logic [15:0] sc_a;
  logic        sf_b, sd_b, se_b, fd_b, fe_b, fm_b, dn_b;
  logic [1:0]  fa_b, fb_b;
  logic [1:0]  sc_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_unit_mdu u_a (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE),
    .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .FlushD(fd_a), .FlushE(fe_a),
    .FlushM(fm_a), .ForwardAE(fa_a), .ForwardBE(fb_a), .MduDoneE(dn_a), .StallCount(sc_a)
  );

  hazard_unit_mdu #(.REG_AW(5), .MDU_LAT(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE),
    .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .FlushD(fd_b), .FlushE(fe_b),
    .FlushM(fm_b), .ForwardAE(fa_b), .ForwardBE(fb_b), .MduDoneE(dn_b), .StallCount(sc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 2'b00; MduStartE = 1'b0;
  endtask

  task automatic set_all_active();
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd6;
    Rs1E = 5'd5; Rs2E = 5'd6;
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    PCSrcE = 2'b01; MduStartE = 1'b1;
  endtask

  initial begin
    // Reset with every input active: all outputs must stay low
    clear_inputs();
    rst = 1'b0;
    set_all_active();
    #3;
    chk("rst_ctrl_a", {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, fa_a, fb_a, dn_a}, 11'd0);
    chk("rst_ctrl_b", {sf_b, sd_b, se_b, fd_b, fe_b, fm_b, fa_b, fb_b, dn_b}, 11'd0);
    cyc();
    chk("rst_cnt_a", sc_a, 16'd0);
    chk("rst_cnt_b", sc_b, 2'd0);

    clear_inputs();
    rst = 1'b1;
    #1;
    chk("idle_ctrl", {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, dn_a}, 7'd0);

    // Forwarding: Memory beats Writeback, x0 never forwards
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd0;
    #1;
    chk("fwdA_mem", fa_a, 2'b10);
    chk("fwdB_x0", fb_a, 2'b00);
    RdM = 5'd0;
    #1;
    chk("fwdA_wb", fa_a, 2'b01);
    RdM = 5'd9; Rs2E = 5'd9;
    #1;
    chk("fwdB_mem", fb_a, 2'b10);
    chk("fwdA_wb2", fa_a, 2'b01);
    RegWriteW = 1'b0;
    #1;
    chk("fwdA_none", fa_a, 2'b00);
    clear_inputs();
    cyc();

    // Load-use on Rs2D: one stall cycle with ID-EX bubble
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    chk("lu_ctrl", {sf_a, sd_a, fe_a, fd_a, se_a, fm_a}, 6'b111000);
    chk("lu_cnt_pre", sc_a, 16'd0);
    cyc();
    ResultSrcE = 2'b00;
    #1;
    chk("lu_cnt_post", sc_a, 16'd1);
    chk("lu_released", {sf_a, sd_a, fe_a}, 3'b000);
    ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0;
    #1;
    chk("lu_rd0", sf_a, 1'b0);
    clear_inputs();
    cyc();

    // Two back-to-back MDU ops: hold,hold,hold,done twice
    MduStartE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if ((i % 4) != 3)
        chk($sformatf("mdu_hold_%0d", i), {se_a, fm_a, sf_a, sd_a, fe_a, fd_a, dn_a}, 7'b1111000);
      else
        chk($sformatf("mdu_done_%0d", i), {se_a, fm_a, sf_a, sd_a, fe_a, fd_a, dn_a}, 7'b0000001);
      chk($sformatf("mdu1_%0d", i), {dn_b, se_b, sf_b}, 3'b100);
      cyc();
    end
    MduStartE = 1'b0;
    #1;
    chk("mdu_cnt_a", sc_a, 16'd7);
    chk("mdu_cnt_b", sc_b, 2'd1);

    // Redirect together with load-use
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 2'b01;
    #1;
    chk("redir_lu", {sf_a, sd_a, fd_a, fe_a, se_a, fm_a}, 6'b111100);
    cyc();
    PCSrcE = 2'b00;

    // Load-use deferred while MDU holds, taken on release
    MduStartE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i != 3)
        chk($sformatf("hold_lu_%0d", i), {se_a, sf_a, sd_a, fe_a, fd_a, dn_a}, 6'b111000);
      else
        chk("rel_lu", {se_a, sf_a, sd_a, fe_a, fd_a, dn_a}, 6'b011101);
      cyc();
    end
    clear_inputs();
    #1;
    chk("cnt_a_12", sc_a, 16'd12);
    chk("sat_b", sc_b, 2'd3);

    // Reset in the middle of an MDU op
    MduStartE = 1'b1;
    cyc();
    cyc();
    #1;
    chk("mid_hold", se_a, 1'b1);
    set_all_active();
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, fa_a, fb_a, dn_a}, 11'd0);
    chk("mid_rst_cnt", sc_a, 16'd0);
    cyc();
    clear_inputs();
    MduStartE = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("restart_%0d", i), {se_a, dn_a}, (i != 3) ? 2'b10 : 2'b01);
      cyc();
    end
    MduStartE = 1'b0;

    // Saturation on the 2-bit counter
    ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
    for (int i = 0; i < 5; i++) cyc();
    clear_inputs();
    #1;
    chk("sat_final_b", sc_b, 2'd3);
    chk("final_a", sc_a, 16'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
